// File: rtl/freq_sweep.sv
// Linear frequency-sweep controller for the NCO tuning word.
// Modes: single sweep, repeating sawtooth, and continuous triangle; each value is held for dwell+1 cycles.
module freq_sweep #(
    parameter int W  = 32,
    parameter int DW = 16
) (
    input  logic          sys_clk,
    input  logic          n_rst,
    input  logic          start,
    input  logic          stop,
    input  logic [W-1:0]  f_start,
    input  logic [W-1:0]  f_stop,
    input  logic [W-1:0]  f_delta,
    input  logic [DW-1:0] dwell,
    input  logic [1:0]    mode,
    output logic [W-1:0]  phase_step,
    output logic          busy,
    output logic          step_stb,
    output logic          done
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, state_nxt;
    logic [W-1:0]  start_l, stop_l, delta_l, tgt, tgt_nxt, ph_nxt;
    logic [DW-1:0] dwell_l, cnt, cnt_nxt;
    logic [1:0]    mode_l;
    logic          up, up_nxt, stb_nxt, done_nxt, latch;
    logic [W-1:0]  delta_eff, tgt_swap;
    logic          at_tgt, is_rep, is_tri;

    // Step toward tgt in W+1 bits, so the word can never wrap; lands exactly on tgt when within one step.
    function automatic logic [W-1:0] step_toward(input logic [W-1:0] cur, input logic [W-1:0] t,
                                                 input logic [W-1:0] dlt, input logic dir_up);
        logic [W:0] sum, diff;
        sum  = {1'b0, cur} + {1'b0, dlt};
        diff = {1'b0, cur} - {1'b0, dlt};
        if (dir_up)
            return (sum >= {1'b0, t}) ? t : sum[W-1:0];
        else
            return (diff[W] || diff <= {1'b0, t}) ? t : diff[W-1:0];
    endfunction

    assign delta_eff = (delta_l == '0) ? {{(W-1){1'b0}}, 1'b1} : delta_l;
    assign at_tgt    = (phase_step == tgt);
    assign is_rep    = (mode_l == 2'b01);
    assign is_tri    = (mode_l == 2'b10);
    assign tgt_swap  = (tgt == stop_l) ? start_l : stop_l;

    // State register
    always_ff @(posedge sys_clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        if (stop) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_nxt = RUN;
                RUN:     if (cnt == '0 && at_tgt && !is_rep && !is_tri) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Output / datapath next values
    always_comb begin
        ph_nxt   = phase_step;
        stb_nxt  = 1'b0;
        done_nxt = 1'b0;
        cnt_nxt  = cnt;
        tgt_nxt  = tgt;
        up_nxt   = up;
        latch    = 1'b0;
        if (!stop) begin
            case (state)
                IDLE: if (start) begin
                    latch   = 1'b1;
                    ph_nxt  = f_start;
                    stb_nxt = 1'b1;
                    cnt_nxt = dwell;
                    tgt_nxt = f_stop;
                    up_nxt  = (f_stop >= f_start);
                end
                RUN: begin
                    if (cnt != '0) begin
                        cnt_nxt = cnt - 1'b1;
                    end else if (!at_tgt) begin
                        ph_nxt  = step_toward(phase_step, tgt, delta_eff, up);
                        stb_nxt = 1'b1;
                        cnt_nxt = dwell_l;
                    end else if (is_rep) begin
                        ph_nxt  = start_l;
                        stb_nxt = 1'b1;
                        cnt_nxt = dwell_l;
                    end else if (is_tri) begin
                        tgt_nxt = tgt_swap;
                        up_nxt  = ~up;
                        ph_nxt  = step_toward(phase_step, tgt_swap, delta_eff, ~up);
                        stb_nxt = 1'b1;
                        cnt_nxt = dwell_l;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge n_rst) begin
        if (!n_rst) begin
            phase_step <= '0;
            busy       <= 1'b0;
            step_stb   <= 1'b0;
            done       <= 1'b0;
            cnt        <= '0;
            tgt        <= '0;
            up         <= 1'b1;
            start_l    <= '0;
            stop_l     <= '0;
            delta_l    <= '0;
            dwell_l    <= '0;
            mode_l     <= 2'b00;
        end else begin
            phase_step <= ph_nxt;
            busy       <= (state_nxt == RUN);
            step_stb   <= stb_nxt;
            done       <= done_nxt;
            cnt        <= cnt_nxt;
            tgt        <= tgt_nxt;
            up         <= up_nxt;
            if (latch) begin
                start_l <= f_start;
                stop_l  <= f_stop;
                delta_l <= f_delta;
                dwell_l <= dwell;
                mode_l  <= mode;
            end
        end
    end

endmodule
